execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_pkg.sv | 40 ++++
 rtl/execute_stage_if.sv | 47 ++++
 rtl/execute_stage_alu.sv | 25 ++
 rtl/execute_stage.sv | 80 ++++++++
 tb/tb_execute_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, forwarding selects, branch funct3 codes.
package execute_stage_pkg;

    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSub  = 3'b001,
        AluAnd  = 3'b010,
        AluOr   = 3'b011,
        AluXor  = 3'b100,
        AluSlt  = 3'b101,
        AluSltu = 3'b110,
        AluSll  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FwdReg     = 2'b00,
        FwdResultW = 2'b01,
        FwdAluM    = 2'b10
    } fwd_sel_e;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    // Unused code 11 falls back to the register-file value.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] result_w,
                                            input logic [31:0] alu_result_m);
        case (sel)
            FwdResultW: return result_w;
            FwdAluM:    return alu_result_m;
            default:    return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage bundled as one bus.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, Funct3E,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
               PCPlus4M, RdM
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, Funct3E,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
               PCPlus4M, RdM
    );

endinterface

// File: rtl/execute_stage_alu.sv
// 32-bit ALU: wrapping arithmetic, logic ops, signed/unsigned set-less-than, shift-left.
module alu
    import execute_stage_pkg::*;
(
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  ALUControl,
    output logic [31:0] ALUResult
);

    always_comb begin
        ALUResult = '0;
        unique case (alu_op_e'(ALUControl))
            AluAdd:  ALUResult = SrcA + SrcB;
            AluSub:  ALUResult = SrcA - SrcB;
            AluAnd:  ALUResult = SrcA & SrcB;
            AluOr:   ALUResult = SrcA | SrcB;
            AluXor:  ALUResult = SrcA ^ SrcB;
            AluSlt:  ALUResult = {31'b0, $signed(SrcA) < $signed(SrcB)};
            AluSltu: ALUResult = {31'b0, SrcA < SrcB};
            AluSll:  ALUResult = SrcA << SrcB[4:0];
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    execute_stage_if.slave ex
);

    logic [31:0] src_a;
    logic [31:0] write_data;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        branch_cond;

    logic        reg_write_q;
    logic        mem_write_q;
    logic [1:0]  result_src_q;
    logic [31:0] alu_result_q;
    logic [31:0] write_data_q;
    logic [31:0] pc_plus4_q;
    logic [4:0]  rd_q;

    assign src_a      = fwd_mux(ex.ForwardAE, ex.RD1E, ex.ResultW, alu_result_q);
    assign write_data = fwd_mux(ex.ForwardBE, ex.RD2E, ex.ResultW, alu_result_q);
    assign src_b      = ex.ALUSrcE ? ex.ImmExtE : write_data;

    alu u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ex.ALUControlE),
        .ALUResult  (alu_result)
    );

    // Branches compare the two register operands, never the immediate.
    always_comb begin
        branch_cond = 1'b0;
        case (ex.Funct3E)
            F3Beq:   branch_cond = (src_a == write_data);
            F3Bne:   branch_cond = (src_a != write_data);
            F3Blt:   branch_cond = ($signed(src_a) < $signed(write_data));
            F3Bge:   branch_cond = ($signed(src_a) >= $signed(write_data));
            F3Bltu:  branch_cond = (src_a < write_data);
            F3Bgeu:  branch_cond = (src_a >= write_data);
            default: branch_cond = 1'b0;
        endcase
    end

    assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & branch_cond);
    assign ex.PCTargetE = ex.PCE + ex.ImmExtE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= ex.RegWriteE;
            mem_write_q  <= ex.MemWriteE;
            result_src_q <= ex.ResultSrcE;
            alu_result_q <= alu_result;
            write_data_q <= write_data;
            pc_plus4_q   <= ex.PCPlus4E;
            rd_q         <= ex.RdE;
        end
    end

    assign ex.RegWriteM  = reg_write_q;
    assign ex.MemWriteM  = mem_write_q;
    assign ex.ResultSrcM = result_src_q;
    assign ex.ALUResultM = alu_result_q;
    assign ex.WriteDataM = write_data_q;
    assign ex.PCPlus4M   = pc_plus4_q;
    assign ex.RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage against a behavioural reference model.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model of the EX/MEM register contents.
    logic        m_regw, m_memw;
    logic [1:0]  m_rsrc;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;

    execute_stage_if bus ();

    execute_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
        if (sel == 2'd1) return bus.ResultW;
        if (sel == 2'd2) return m_alu;
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint r;
        case (op)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub;
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(a | b);
            3'd4: r = longint'(a ^ b);
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: r = (ua < ub) ? 1 : 0;
            default: r = ua * (longint'(1) << (ub % 32));
        endcase
        return r[31:0];
    endfunction

    function automatic bit ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        case (f3)
            3'd0: return sa == sb;
            3'd1: return sa != sb;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.BranchE = 0; bus.ALUSrcE = 0;
        bus.ResultSrcE = 0; bus.ALUControlE = 0; bus.Funct3E = 3'b010;
        bus.RD1E = 0; bus.RD2E = 0; bus.ImmExtE = 0; bus.PCE = 0; bus.PCPlus4E = 0;
        bus.RdE = 0; bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
    endtask

    task automatic random_inputs();
        bus.RegWriteE = 1'($urandom); bus.MemWriteE = 1'($urandom);
        bus.JumpE = ($urandom_range(0, 5) == 0); bus.BranchE = 1'($urandom);
        bus.ALUSrcE = 1'($urandom); bus.ResultSrcE = 2'($urandom);
        bus.ALUControlE = 3'($urandom); bus.Funct3E = 3'($urandom);
        bus.RD1E = $urandom;
        bus.RD2E = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
        bus.ImmExtE = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        bus.PCE = $urandom; bus.PCPlus4E = $urandom; bus.RdE = 5'($urandom);
        bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom); bus.ResultW = $urandom;
    endtask

    // One cycle: check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic step(input string tag);
        logic [31:0] a, wd, b, res;
        bit          tk;
        @(negedge clk);
        a   = pick(bus.ForwardAE, bus.RD1E);
        wd  = pick(bus.ForwardBE, bus.RD2E);
        b   = bus.ALUSrcE ? bus.ImmExtE : wd;
        res = ref_alu(bus.ALUControlE, a, b);
        tk  = bus.JumpE || (bus.BranchE && ref_branch(bus.Funct3E, a, wd));
        check({tag, ".pcsrc"}, {31'b0, bus.PCSrcE}, {31'b0, tk});
        check({tag, ".pctgt"}, bus.PCTargetE, 32'(bus.PCE + bus.ImmExtE));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_regw = 0; m_memw = 0; m_rsrc = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        end else begin
            m_regw = bus.RegWriteE; m_memw = bus.MemWriteE; m_rsrc = bus.ResultSrcE;
            m_alu = res; m_wd = wd; m_pc4 = bus.PCPlus4E; m_rd = bus.RdE;
        end
        check({tag, ".regw"}, {31'b0, bus.RegWriteM}, {31'b0, m_regw});
        check({tag, ".memw"}, {31'b0, bus.MemWriteM}, {31'b0, m_memw});
        check({tag, ".rsrc"}, {30'b0, bus.ResultSrcM}, {30'b0, m_rsrc});
        check({tag, ".alu"}, bus.ALUResultM, m_alu);
        check({tag, ".wd"}, bus.WriteDataM, m_wd);
        check({tag, ".pc4"}, bus.PCPlus4M, m_pc4);
        check({tag, ".rd"}, {27'b0, bus.RdM}, {27'b0, m_rd});
    endtask

    initial begin
        m_regw = 0; m_memw = 0; m_rsrc = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        clear_inputs();

        // Reset held two cycles with write controls asserted.
        rst_n = 0; bus.RegWriteE = 1; bus.MemWriteE = 1; bus.RD1E = 32'h55; bus.RdE = 5'd9;
        step("rst0");
        step("rst1");
        check("rst.memw_const", {31'b0, bus.MemWriteM}, 32'd0);
        rst_n = 1;

        // Add with immediate.
        clear_inputs();
        bus.RD1E = 5; bus.ImmExtE = 7; bus.ALUSrcE = 1; bus.RdE = 3;
        step("add");
        check("add.const", bus.ALUResultM, 32'd12);
        check("add.rd_const", {27'b0, bus.RdM}, 32'd3);

        // Forwarding chain: 1+2, then (forwarded 3) - 4, then WriteData from ResultW.
        clear_inputs();
        bus.RD1E = 1; bus.RD2E = 2;
        step("chain0");
        bus.ForwardAE = 2'b10; bus.RD1E = 32'hDEAD; bus.RD2E = 4; bus.ALUControlE = 3'b001;
        step("chain1");
        check("chain.sub_const", bus.ALUResultM, 32'hFFFF_FFFF);
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b01; bus.ResultW = 9; bus.ALUControlE = 0;
        step("chain2");
        check("chain.wd_const", bus.WriteDataM, 32'd9);
        bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b11; bus.RD1E = 32'h10; bus.RD2E = 32'h20;
        step("fwd11");

        // Branches: signed vs unsigned, and target wrap.
        clear_inputs();
        bus.BranchE = 1; bus.Funct3E = 3'b100; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 1;
        bus.ALUSrcE = 1; bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
        #2;
        check("blt.const", {31'b0, bus.PCSrcE}, 32'd1);
        check("tgt.const", bus.PCTargetE, 32'h0000_00F8);
        step("blt");
        bus.Funct3E = 3'b110;
        #2;
        check("bltu.const", {31'b0, bus.PCSrcE}, 32'd0);
        step("bltu");
        bus.Funct3E = 3'b010; bus.RD2E = 32'hFFFF_FFFF;
        #2;
        check("f3_010.const", {31'b0, bus.PCSrcE}, 32'd0);
        step("f3_010");

        // Jump.
        clear_inputs();
        bus.JumpE = 1; bus.PCPlus4E = 32'h24;
        #2;
        check("jal.const", {31'b0, bus.PCSrcE}, 32'd1);
        step("jal");
        check("jal.pc4_const", bus.PCPlus4M, 32'h24);

        // Wrap, sltu, shift amount masking.
        clear_inputs();
        bus.RD1E = 32'h7FFF_FFFF; bus.ImmExtE = 1; bus.ALUSrcE = 1;
        step("wrap");
        check("wrap.const", bus.ALUResultM, 32'h8000_0000);
        clear_inputs();
        bus.RD1E = 1; bus.RD2E = 32'hFFFF_FFFF; bus.ALUControlE = 3'b110;
        step("sltu");
        check("sltu.const", bus.ALUResultM, 32'd1);
        clear_inputs();
        bus.RD1E = 3; bus.ImmExtE = 33; bus.ALUSrcE = 1; bus.ALUControlE = 3'b111;
        step("sll");
        check("sll.const", bus.ALUResultM, 32'd6);

        // Randomized stream with occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            rst_n = ($urandom_range(0, 24) != 0);
            if (!rst_n) bus.MemWriteE = 1;
            step("rand");
        end
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
